// File: rtl/tpu_result_packer.sv
// Converts a stream of Float15 accumulator results into Float8 and packs them
// into a LANES-wide vector, handing the vector off with a valid/ready handshake.
module tpu_result_packer #(
  parameter int LANES = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [14:0]        in_data,
  input  logic               in_overflow,
  input  logic               relu_en,
  input  logic [7:0]         vec_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*8-1:0] out_data,
  output logic               sat_flag
);

  // Wide enough for both LANES itself and any 8-bit vec_len compared against it.
  localparam int LEN_W = ($clog2(LANES + 1) > 9) ? $clog2(LANES + 1) : 9;

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_req;
  logic [LEN_W-1:0] len_cur;
  logic [LEN_W-1:0] idx_next;
  logic             accept;

  logic [3:0]       mant_sum;
  logic [4:0]       exp_sum;
  logic [7:0]       conv_byte;
  logic             conv_sat;

  assign accept   = in_valid && in_ready;
  assign idx_next = idx + 1'b1;

  always_comb begin
    len_req = LEN_W'(vec_len);
    if (vec_len == 8'd0 || len_req > LEN_W'(LANES)) begin
      len_req = LEN_W'(LANES);
    end
  end

  // The first accept of a vector uses the live vec_len; later ones the latched copy.
  assign len_cur = (idx == '0) ? len_req : len_q;

  // Float15 -> Float8: round half away from zero on mantissa bit 6.
  always_comb begin
    mant_sum  = {1'b0, in_data[9:7]} + {3'b000, in_data[6]};
    exp_sum   = {1'b0, in_data[13:10]} + {4'b0000, mant_sum[3]};
    conv_byte = {in_data[14], exp_sum[3:0], mant_sum[2:0]};
    conv_sat  = 1'b0;
    if (relu_en && in_data[14]) begin
      conv_byte = 8'h00;
    end else if (in_overflow) begin
      conv_byte = {in_data[14], 7'h7F};
      conv_sat  = 1'b1;
    end else if (in_data[13:10] == 4'h0) begin
      conv_byte = 8'h00;
    end else if (exp_sum[4]) begin
      conv_byte = {in_data[14], 7'h7F};
      conv_sat  = 1'b1;
    end
  end

  // NOTE: every register here updates with <= so all of them see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      idx       <= '0;
      len_q     <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < LANES; i++) begin
              if (idx == LEN_W'(i)) begin
                out_data[8*i +: 8] <= conv_byte;
              end
            end
            sat_flag <= sat_flag | conv_sat;
            if (idx == '0) begin
              len_q <= len_req;
            end
            idx <= idx_next;
            if (idx_next == len_cur) begin
              state     <= FULL;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= '0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/tpu_result_packer.md
TPU_RESULT_PACKER -- requirements
Module: tpu_result_packer

Interface
REQ-001 The block SHALL have parameter LANES, default 128, giving the number of Float8 lanes in the packed output vector.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data/in_overflow are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a result this cycle.
REQ-006 The block SHALL have port in_data, input, 15 bits: accumulated Float15 dot-product result.
REQ-007 The block SHALL have port in_overflow, input, 1 bit: the accumulator overflowed for this result.
REQ-008 The block SHALL have port relu_en, input, 1 bit: apply ReLU during conversion.
REQ-009 The block SHALL have port vec_len, input, 8 bits: results per vector; 0 means LANES; values above LANES clamp to LANES.
REQ-010 The block SHALL have port out_valid, output, 1 bit: packed vector available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the vector.
REQ-012 The block SHALL have port out_data, output, LANES*8 bits: packed Float8 vector; lane i occupies bits [8i+7:8i].
REQ-013 The block SHALL have port sat_flag, output, 1 bit: sticky flag; some lane of the current vector saturated.

Function
REQ-014 Float15 format SHALL be sign[14], exponent[13:10] (bias 7), mantissa[9:0]; Float8 format SHALL be sign[7], exponent[6:3] (bias 7), mantissa[2:0].
REQ-015 Conversion SHALL round to nearest on mantissa bit 6 (ties away from zero): mant8 = in_data[9:7] + in_data[6]; a mantissa carry increments the exponent.
REQ-016 If the exponent field is 0, the output SHALL be 0x00 (flush, sign dropped).
REQ-017 If in_overflow=1, or rounding carries the exponent past 4'hF, the output SHALL saturate to {sign,7'h7F} and set sat_flag.
REQ-018 If relu_en=1 and the converted sign is 1, the output SHALL be 0x00 and no saturation SHALL be recorded for that lane.
REQ-019 An accept SHALL occur when in_valid && in_ready; the converted byte is written to lane idx, and idx increments.
REQ-020 The block SHALL use two states. COLLECT: in_ready=1 and out_valid=0. FULL: in_ready=0 and out_valid=1.
REQ-021 The effective length SHALL be latched from vec_len on the first accept of each vector and be ignored during the rest of the vector.
REQ-022 COLLECT->FULL SHALL happen on the accept that makes idx equal to the latched length; out_valid SHALL go high the next cycle with all lanes written.
REQ-023 Lanes at or above the latched length SHALL read 0x00.
REQ-024 FULL->COLLECT SHALL happen on out_valid && out_ready. On that edge idx:=0, all lanes:=0, and sat_flag:=0; in_ready SHALL be 1 on the following cycle.
REQ-025 out_data and sat_flag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 in_valid while in FULL SHALL be ignored (no accept, no state change); the source must hold its data.
REQ-027 Latency SHALL be 1 cycle from the final accept to out_valid; accept throughput SHALL be 1 result per cycle in COLLECT.
REQ-028 A LANES=1 or length-1 vector SHALL enter FULL after one accept.

Reset
REQ-029 On rst=1 at a clock edge: state:=COLLECT, idx:=0, out_data:=0, out_valid:=0, sat_flag:=0, in_ready:=1 from the next cycle.
REQ-030 Reset mid-vector or in FULL SHALL discard the partial or pending vector without any out_valid pulse; rst SHALL dominate simultaneous accepts and out_ready.

Verification
REQ-031 Full vector: vec_len=0, feed 128 results of 15'h1E00 (exp 7, mant 1000000000) back-to-back -> out_valid rises 1 cycle after the 128th accept; every lane = 0x3C; sat_flag=0.
REQ-032 Rounding and saturation: 15'h1FC0 -> lane 0x40 (carry into exponent); 15'h3FC0 -> 0x7F with sat_flag=1; 15'h0000 with in_overflow=1 -> 0x7F.
REQ-033 ReLU: relu_en=1, vec_len=2, inputs 15'h5E00 and 15'h1E00 -> lanes 0x00, 0x3C; lanes 2..127 = 0; sat_flag=0.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in FULL while driving in_valid=1 -> in_ready=0, out_data constant; assert out_ready -> one handshake, then in_ready=1 and out_data=0.
REQ-035 Reset mid-vector: accept 5 results, assert rst for 1 cycle, then run a length-3 vector -> out_valid only after 3 new accepts; lanes 3..127 = 0.
